// File: rtl/led_demux_pkg.sv
// rtl/led_demux_pkg.sv - shared widths and types for the LED demultiplexer
package led_demux_pkg;

  localparam int NUM_LEDS = 4;
  localparam int SEL_W    = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - 2-flop synchronizer, debounce counter and press pulse
// for one asynchronous switch input.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    sync1_d     = i_Switch;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    level_d     = level_q;
    count_d     = '0;
    // Any cycle where the synchronized level agrees with the accepted state restarts the count.
    if (sync2_q != level_q) begin
      if (count_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      count_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      count_q     <= count_d;
    end
  end

  assign o_Level = level_q;
  assign o_Press = level_q & ~level_dly_q;

endmodule

// File: rtl/led_demux_1_to_4.sv
// rtl/led_demux_1_to_4.sv - routes i_Data to one of four LEDs chosen by two debounced switches.
// Optional blink gating of the selected LED is built when DEMUX_BLINK_EN is defined.
module led_demux_1_to_4
  import led_demux_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int BLINK_LIMIT    = 12500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Data,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4,
  output logic [SEL_W-1:0] o_Sel
);

  if (DEBOUNCE_LIMIT < 1 || BLINK_LIMIT < 2) begin : g_param_check
    $error("led_demux_1_to_4: DEBOUNCE_LIMIT must be >= 1 and BLINK_LIMIT >= 2");
  end

  logic press1, press2;
  logic level1, level2;

  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw1 (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch_1),
    .o_Level (level1),
    .o_Press (press1)
  );

  switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw2 (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch_2),
    .o_Level (level2),
    .o_Press (press2)
  );

  sel_t                sel_q, sel_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                routed;

`ifdef DEMUX_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_LIMIT);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_LIMIT - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign routed = i_Data & blink_q;
`else
  assign routed = i_Data;
`endif

  always_comb begin
    sel_d = sel_q;
    // Simultaneous advance and retreat cancel out.
    case ({press1, press2})
      2'b10:   sel_d = sel_t'(sel_q + 1'b1);
      2'b01:   sel_d = sel_t'(sel_q - 1'b1);
      default: sel_d = sel_q;
    endcase
  end

  // LEDs decode the registered selection, so they trail o_Sel by one cycle and stay one-hot.
  always_comb begin
    led_d        = '0;
    led_d[sel_q] = routed;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sel_q <= '0;
      led_q <= '0;
    end else begin
      sel_q <= sel_d;
      led_q <= led_d;
    end
  end

  assign o_Sel   = sel_q;
  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_demux_1_to_4.sv
// tb/tb_led_demux_1_to_4.sv - directed and random checks of led_demux_1_to_4 against a window-based reference model
module tb_led_demux_1_to_4;

  localparam int DL = 4;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw1, sw2, data;
  logic       led1, led2, led3, led4;
  logic [1:0] sel;

  int n_cmp = 0;
  int n_bad = 0;

  led_demux_1_to_4 #(.DEBOUNCE_LIMIT(DL), .BLINK_LIMIT(BL)) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .i_Data    (data),
    .o_LED_1   (led1),
    .o_LED_2   (led2),
    .o_LED_3   (led3),
    .o_LED_4   (led4),
    .o_Sel     (sel)
  );

  always #5 clk = ~clk;

  // Reference: a switch's accepted level flips at edge k when the pin samples taken at
  // edges k-DL-1 .. k-2 all disagree with it and at least DL edges passed since its last flip.
  bit       h1[$], h2[$];
  int       k;
  bit       lv1, lv2;
  int       lf1, lf2;
  bit       rise1, rise2;
  int       m_sel;
  bit [3:0] m_led;
  int       blink_phase;

  function automatic bit hget(input bit q[$], input int idx);
    if (idx < 0 || idx >= q.size()) return 1'b0;
    return q[idx];
  endfunction

  function automatic bit flip_ok(input bit q[$], input bit lv, input int kk, input int lf);
    if (kk - lf < DL) return 1'b0;
    for (int i = 2; i <= DL + 1; i++)
      if (hget(q, kk - i) == lv) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    h1.delete(); h2.delete();
    k = 0; lv1 = 0; lv2 = 0; lf1 = -100; lf2 = -100;
    rise1 = 0; rise2 = 0; m_sel = 0; m_led = '0; blink_phase = 0;
  endtask

  task automatic model_edge();
    bit routed;
    bit n1, n2;
`ifdef DEMUX_BLINK_EN
    routed = data && ((blink_phase / BL) % 2 == 1);
`else
    routed = data;
`endif
    blink_phase++;
    m_led = '0;
    m_led[m_sel] = routed;
    if (rise1 && !rise2) m_sel = (m_sel + 1) % 4;
    if (rise2 && !rise1) m_sel = (m_sel + 3) % 4;
    n1 = 0; n2 = 0;
    if (flip_ok(h1, lv1, k, lf1)) begin lv1 = !lv1; lf1 = k; n1 = lv1; end
    if (flip_ok(h2, lv2, k, lf2)) begin lv2 = !lv2; lf2 = k; n2 = lv2; end
    rise1 = n1; rise2 = n2;
    h1.push_back(sw1);
    h2.push_back(sw2);
    k++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("sel", int'(sel), m_sel);
    chk("leds", int'({led4, led3, led2, led1}), int'(m_led));
    chk("onehot", int'($countones({led4, led3, led2, led1}) <= 1), 1);
  endtask

  task automatic tick(input bit s1, input bit s2, input bit d);
    sw1 = s1; sw2 = s2; data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic press(input bit s1, input bit s2, output int lat);
    int prev;
    prev = int'(sel);
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      tick(s1, s2, 1'b1);
      if (lat == 0 && int'(sel) != prev) lat = t;
    end
    for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, 1'b1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; sw1 = 0; sw2 = 0; data = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_sel", int'(sel), 0);
    chk("reset_leds", int'({led4, led3, led2, led1}), 0);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) tick(1'b0, 1'b0, 1'b1);
    chk("hold_sel", int'(sel), 0);
`ifndef DEMUX_BLINK_EN
    chk("hold_led1", int'(led1), 1);
`endif

    for (int p = 0; p < 4; p++) begin
      press(1'b1, 1'b0, lat);
      chk("clean_step", int'(sel), (p + 1) % 4);
      chk("clean_latency", lat, 7);
    end

    for (int t = 0; t < 20; t++) tick(bit'((t / 2) % 2 == 0), 1'b0, 1'b1);
    for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, 1'b1);
    chk("bounce_sel", int'(sel), 0);

    press(1'b0, 1'b1, lat);
    chk("retreat_wrap", int'(sel), 3);
`ifndef DEMUX_BLINK_EN
    chk("retreat_led4", int'(led4), 1);
`endif
    press(1'b1, 1'b1, lat);
    chk("both_hold", int'(sel), 3);

    for (int p = 0; p < 3; p++) press(1'b1, 1'b0, lat);
    chk("pre_reset_sel", int'(sel), 2);
    for (int t = 0; t < 5; t++) tick(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_sel", int'(sel), 0);
    chk("midreset_leds", int'({led4, led3, led2, led1}), 0);
    model_reset();
    @(negedge clk);
    sw1 = 0;
    rst_n = 1'b1;
    for (int t = 0; t < 15; t++) tick(1'b0, 1'b0, 1'b1);
    chk("post_reset_sel", int'(sel), 0);

    for (int s = 0; s < 300; s++) begin
      bit r1, r2;
      int len;
      r1  = bit'($urandom_range(0, 1));
      r2  = bit'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int t = 0; t < len; t++) tick(r1, r2, bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
